// File: rtl/modexp_scheduler.sv
// ---------------------------------------------------------------------------
// modexp_scheduler
//
// Control-only sequencer for left-to-right binary modular exponentiation on
// a Montgomery multiplier. It issues one Montgomery multiply at a time over a
// start/done handshake. Each multiply is named by an operand-select code, and
// the datapath uses that code to steer the multiplier operands and the
// destination register. This block holds the exponent and the loop state
// only. It never sees operand data.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   reset     in   asynchronous active-high reset
//   start     in   request a new exponentiation (sampled only in IDLE)
//   exponent  in   exponent value, latched on accepted start
//   exp_len   in   significant exponent bits, latched with exponent
//                  (values above E_BITS are clamped)
//   busy      out  high from the first ISSUE cycle through the DONE cycle
//   done      out  one-cycle pulse when the result is complete
//   x_init    out  one-cycle pulse in the first ISSUE cycle: X <= R mod N
//   mm_start  out  one-cycle pulse starting a Montgomery multiply
//   mm_op     out  operation select
//                    00 Mbar <= MM(M, R2)
//                    01 X    <= MM(X, X)
//                    10 X    <= MM(X, Mbar)
//                    11 X    <= MM(X, 1)
//   mm_done   in   multiplier completion pulse (honoured only in WAIT)
//   op_count  out  mm_start pulses issued in the current or last run
//
// Every output is driven straight from a flop. No input has a
// combinational path to an output.
// ---------------------------------------------------------------------------
module modexp_scheduler #(
    parameter int E_BITS = 1024,
    parameter int LEN_W  = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [E_BITS-1:0] exponent,
    input  logic [LEN_W-1:0]  exp_len,
    output logic              busy,
    output logic              done,
    output logic              x_init,
    output logic              mm_start,
    output logic [1:0]        mm_op,
    input  logic              mm_done,
    output logic [CNT_W-1:0]  op_count
);

    localparam int IDX_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(E_BITS);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SQR   = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam logic [1:0] OP_FINAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t             state_q,    state_d;
    logic [E_BITS-1:0]  exp_q,      exp_d;
    logic [LEN_W-1:0]   bitsLeft_q, bitsLeft_d;
    logic [1:0]         op_q,       op_d;
    logic [CNT_W-1:0]   opCount_q,  opCount_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               xInit_q,    xInit_d;
    logic               mmStart_q,  mmStart_d;

    // bitsLeft_q counts the exponent bits not yet fully processed. The bit
    // being worked on is therefore bitsLeft_q-1. Keeping a count rather than
    // an index lets exp_len = 0 mean "no bits" without any wrap-around.
    logic [LEN_W-1:0]   bitsAfter;
    logic [IDX_W-1:0]   bitIdx;
    logic               curBit;

    assign bitsAfter = bitsLeft_q - 1'b1;
    assign bitIdx    = IDX_W'(bitsAfter);
    assign curBit    = exp_q[bitIdx];

    // Next-state logic. The output flops are loaded from the next state,
    // so each output is valid in the same cycle as the state it describes.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        bitsLeft_d = bitsLeft_q;
        op_d       = op_q;
        opCount_d  = opCount_q;
        xInit_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d      = exponent;
                    bitsLeft_d = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;
                    opCount_d  = '0;
                    op_d       = OP_LOAD;
                    xInit_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (opCount_q != '1) begin
                    opCount_d = opCount_q + 1'b1;
                end
                state_d = S_WAIT;
            end

            // A square is followed by a multiply only when the current
            // exponent bit is set. The bit is retired after whichever of
            // the two comes last. The final op follows once the bit at
            // index 0 has been retired.
            S_WAIT: begin
                if (mm_done) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_LOAD: begin
                            op_d = (bitsLeft_q == '0) ? OP_FINAL : OP_SQR;
                        end
                        OP_SQR: begin
                            if (curBit) begin
                                op_d = OP_MUL;
                            end else begin
                                bitsLeft_d = bitsAfter;
                                op_d = (bitsAfter == '0) ? OP_FINAL : OP_SQR;
                            end
                        end
                        OP_MUL: begin
                            bitsLeft_d = bitsAfter;
                            op_d = (bitsAfter == '0) ? OP_FINAL : OP_SQR;
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        mmStart_d = (state_d == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers. An asynchronous reset aborts a run at
    // once. Any mm_done that arrives afterwards lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            exp_q      <= '0;
            bitsLeft_q <= '0;
            op_q       <= OP_LOAD;
            opCount_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            xInit_q    <= 1'b0;
            mmStart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            bitsLeft_q <= bitsLeft_d;
            op_q       <= op_d;
            opCount_q  <= opCount_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            xInit_q    <= xInit_d;
            mmStart_q  <= mmStart_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign x_init   = xInit_q;
    assign mm_start = mmStart_q;
    assign mm_op    = op_q;
    assign op_count = opCount_q;

endmodule

// File: doc/modexp_scheduler.md
Name: modexp_scheduler

Overview:
- Control-only sequencer for the Montgomery multiplier in the RSA datapath. It runs left-to-right binary modular exponentiation by issuing a sequence of Montgomery multiply operations, one at a time, through a start/done handshake.
- Each operation is named by an operand-select code. The datapath muxes use that code to pick the multiplier operands and the destination register.
- The block holds the exponent and the loop state. It never touches 1024-bit operand data.

Parameters:
- E_BITS, 1024, maximum exponent width in bits.
- LEN_W, 11, width of exp_len; must hold the value E_BITS, so at least clog2(E_BITS+1).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new exponentiation; sampled only in IDLE.
- exponent  in  E_BITS  exponent value; latched when start is accepted.
- exp_len  in  LEN_W  number of significant exponent bits; latched with exponent.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse when the result is complete.
- x_init  out  1  one-cycle pulse; the datapath loads X <= R mod N.
- mm_start  out  1  one-cycle pulse that starts a Montgomery multiply.
- mm_op  out  2  operation select:
  - 00: Mbar <= MM(M, R2)
  - 01: X <= MM(X, X)
  - 10: X <= MM(X, Mbar)
  - 11: X <= MM(X, 1)
- mm_done  in  1  one-cycle pulse from the multiplier; the result is written.
- op_count  out  CNT_W  number of mm_start pulses issued in the current or last run.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy, done, x_init, mm_start = 0; mm_op = 00; op_count = 0.
  - Internal exponent register and bit index are cleared.
  - Reset mid-run aborts immediately. No further mm_start is issued, and a late mm_done is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On the edge where start=1, the block latches exponent and exp_len.
  - If exp_len > E_BITS, it is clamped to E_BITS.
  - op_count is cleared, the next op is set to 00, and the state goes to ISSUE.
  - x_init pulses during the first ISSUE cycle of the run only.
- ISSUE (exactly one cycle):
  - mm_start=1 and mm_op carries the current op.
  - op_count increments on this edge; it saturates at all-ones.
  - Next state is WAIT.
- WAIT:
  - mm_op is held stable.
  - mm_done is sampled only in WAIT. In any other state it is ignored.
  - On mm_done, the next op is computed and the state goes to ISSUE, or to DONE after op 11.
  - The multiplier is assumed to take at least 1 cycle; mm_done may arrive in the first WAIT cycle.
- Op sequence (bit index i runs from exp_len-1 down to 0, MSB first):
  - First op is 00.
  - For each bit i: op 01, then op 10 if exponent[i]=1.
  - Final op is 11.
  - If exp_len=0, the sequence is 00 then 11 (result = 1).
- Bit index:
  - Decrements after the 01/10 pair for a bit completes.
  - Loop exit happens when the bit at index 0 has been processed; there is no wrap-around.
- DONE (one cycle): done=1, busy=1; next state is IDLE.
- busy:
  - Rises the cycle after start is accepted (i.e. in the first ISSUE cycle).
  - Falls when the state returns to IDLE.
- start handling:
  - start in ISSUE, WAIT or DONE is ignored; it is not queued.
  - Back-to-back runs: start may be asserted in the first IDLE cycle after DONE.
- op_count keeps its value after done until the next accepted start.
- All outputs are registered, with no combinational path from inputs to outputs.
- Total ops per run = 2 + exp_len + popcount(exponent[exp_len-1:0]).

Test Plan:
- exponent=0xB, exp_len=4, multiplier responding 3 cycles after each mm_start -> mm_op sequence 00,01,10,01,01,10,01,10,11; one done pulse; op_count=9; x_init pulses exactly once.
- exp_len=0, exponent=0xFF -> ops 00,11 only; op_count=2; done pulses once.
- exponent all ones, exp_len=1024, mm_done 1 cycle after each mm_start -> 2050 ops; the last op is 11; busy is continuous until the DONE cycle.
- start held high throughout a run with exponent=0x5, exp_len=3 -> extra start is ignored; a new run begins only in the IDLE cycle after done; ops 00,01,10,01,01,10,11 for each run.
- reset asserted in WAIT during op 01, with mm_done pulsed afterwards -> all outputs go to 0 immediately; state is IDLE; no mm_start follows until a new start.
- Spurious mm_done in IDLE and ISSUE, plus exp_len=2000 with exponent=0x1 -> stray pulses have no effect; exp_len is clamped to 1024; ops are 00, 1023×01, 01, 10, 11; op_count=1027.
